// File: rtl/seg7_scan_driver_if.sv
// Connects the mips digit patterns to the scan driver and carries the multiplexed display outputs.
interface seg7_scan_driver_if;
  logic       i_En;
  logic [6:0] i_Seg_first;
  logic [6:0] i_Seg_second;
  logic [6:0] i_Seg_third;
  logic [6:0] i_Seg_fourth;
  logic [6:0] i_Seg_fifth;
  logic [6:0] o_Seg;
  logic [4:0] o_An;
  logic [2:0] o_Digit;
  logic       o_Frame_Start;

  modport master (
    output i_En, i_Seg_first, i_Seg_second, i_Seg_third, i_Seg_fourth, i_Seg_fifth,
    input  o_Seg, o_An, o_Digit, o_Frame_Start
  );

  modport slave (
    input  i_En, i_Seg_first, i_Seg_second, i_Seg_third, i_Seg_fourth, i_Seg_fifth,
    output o_Seg, o_An, o_Digit, o_Frame_Start
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexes five 7-segment patterns onto one common-anode bus with a blanking
// gap before each digit; all five patterns are captured once per frame.
module seg7_scan_driver #(
  parameter int unsigned CLK_DIV        = 50000,
  parameter int unsigned BLANK_CYCLES   = 8,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input logic              i_Clk,
  input logic              i_Rst,
  seg7_scan_driver_if.slave bus
);

  localparam int unsigned CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX) + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;

  localparam logic [6:0]    SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [CW-1:0] DRIVE_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [1:0]    GAP_STATE  = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [2:0]      idx_q,   idx_d;
  logic [4:0][6:0] snap_q,  snap_d;
  logic [6:0]      seg_q,   seg_d;
  logic [4:0]      an_q,    an_d;
  logic [2:0]      digit_q, digit_d;
  logic            frame_q, frame_d;
  logic [4:0][6:0] live;

  assign live = {bus.i_Seg_fifth, bus.i_Seg_fourth, bus.i_Seg_third,
                 bus.i_Seg_second, bus.i_Seg_first};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    frame_d = 1'b0;
    if (!bus.i_En) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = GAP_STATE;
          cnt_d   = '0;
          idx_d   = '0;
          snap_d  = live;
          frame_d = 1'b1;
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_DRIVE: begin
          if (cnt_q == DRIVE_LAST) begin
            state_d = GAP_STATE;
            cnt_d   = '0;
            if (idx_q == 3'd4) begin
              idx_d   = '0;
              snap_d  = live;
              frame_d = 1'b1;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Outputs decode the next state so they switch on the same edge as the FSM.
  always_comb begin
    seg_d   = SEG_OFF;
    an_d    = '1;
    digit_d = idx_d;
    if (state_d == ST_DRIVE) begin
      an_d = ~(5'd1 << idx_d);
      case (idx_d)
        3'd0:    seg_d = snap_d[0];
        3'd1:    seg_d = snap_d[1];
        3'd2:    seg_d = snap_d[2];
        3'd3:    seg_d = snap_d[3];
        3'd4:    seg_d = snap_d[4];
        default: seg_d = SEG_OFF;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      snap_q  <= {5{SEG_OFF}};
      seg_q   <= SEG_OFF;
      an_q    <= '1;
      digit_q <= '0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      digit_q <= digit_d;
      frame_q <= frame_d;
    end
  end

  assign bus.o_Seg         = seg_q;
  assign bus.o_An          = an_q;
  assign bus.o_Digit       = digit_q;
  assign bus.o_Frame_Start = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench: a 4/1 blank-gap instance and a 2/0 no-gap instance share clock and reset.
module tb_seg7_scan_driver;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  seg7_scan_driver_if bus_a ();
  seg7_scan_driver_if bus_b ();

  seg7_scan_driver #(.CLK_DIV(4), .BLANK_CYCLES(1), .SEG_ACTIVE_LOW(1'b1)) dut_a (
    .i_Clk (clk),
    .i_Rst (rst_n),
    .bus   (bus_a.slave)
  );

  seg7_scan_driver #(.CLK_DIV(2), .BLANK_CYCLES(0), .SEG_ACTIVE_LOW(1'b1)) dut_b (
    .i_Clk (clk),
    .i_Rst (rst_n),
    .bus   (bus_b.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack_a();
    return {16'd0, bus_a.o_Frame_Start, bus_a.o_Digit, bus_a.o_An, bus_a.o_Seg};
  endfunction

  function automatic logic [31:0] pack_b();
    return {16'd0, bus_b.o_Frame_Start, bus_b.o_Digit, bus_b.o_An, bus_b.o_Seg};
  endfunction

  function automatic logic [31:0] exp_word(input logic fs, input int d, input logic drive,
                                           input logic [6:0] seg);
    logic [4:0] an;
    an = drive ? (5'b11111 ^ (5'b00001 << d)) : 5'b11111;
    return {16'd0, fs, 3'(d), an, drive ? seg : 7'h7F};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame of dut_a: k%5==0 is the blank cycle of digit k/5, the rest drive it.
  task automatic run_a_frame(input string tag, input logic [4:0][6:0] pats,
                             input int mod_k, input int stop_k);
    for (int k = 0; k <= stop_k; k++) begin
      tick();
      chk(tag, pack_a(), exp_word(k == 0, k / 5, (k % 5) != 0, pats[k / 5]));
      if (k == mod_k) bus_a.i_Seg_first = 7'h00;
    end
  endtask

  always @(negedge clk) begin
    chk("an_onehot_a", 32'($countones(~bus_a.o_An) <= 1), 32'd1);
    chk("an_onehot_b", 32'($countones(~bus_b.o_An) <= 1), 32'd1);
  end

  initial begin
    logic [4:0][6:0] p1, p2, p3;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus_a.i_En = 1'b0;
    bus_b.i_En = 1'b0;
    bus_a.i_Seg_first  = 7'h40; bus_a.i_Seg_second = 7'h79; bus_a.i_Seg_third = 7'h24;
    bus_a.i_Seg_fourth = 7'h30; bus_a.i_Seg_fifth  = 7'h19;
    bus_b.i_Seg_first  = 7'h40; bus_b.i_Seg_second = 7'h79; bus_b.i_Seg_third = 7'h24;
    bus_b.i_Seg_fourth = 7'h30; bus_b.i_Seg_fifth  = 7'h19;
    p1 = {7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
    p2 = {7'h19, 7'h30, 7'h24, 7'h79, 7'h00};
    p3 = {7'h19, 7'h30, 7'h24, 7'h02, 7'h12};

    tick();
    tick();
    chk("reset_a", pack_a(), {16'd0, 1'b0, 3'd0, 5'b11111, 7'h7F});
    chk("reset_b", pack_b(), {16'd0, 1'b0, 3'd0, 5'b11111, 7'h7F});
    rst_n = 1'b1;
    tick();
    chk("idle_a", pack_a(), {16'd0, 1'b0, 3'd0, 5'b11111, 7'h7F});

    bus_a.i_En = 1'b1;
    run_a_frame("frame1", p1, -1, 24);
    run_a_frame("frame2", p1, 11, 24);
    run_a_frame("frame3", p2, -1, 24);
    run_a_frame("frame4", p2, -1, 16);

    bus_a.i_En = 1'b0;
    tick();
    chk("disable", pack_a(), {16'd0, 1'b0, 3'd0, 5'b11111, 7'h7F});
    tick();
    chk("disable_hold", pack_a(), {16'd0, 1'b0, 3'd0, 5'b11111, 7'h7F});

    bus_a.i_Seg_first  = 7'h12;
    bus_a.i_Seg_second = 7'h02;
    bus_a.i_En = 1'b1;
    run_a_frame("reenable", p3, -1, 24);
    bus_a.i_En = 1'b0;
    tick();

    bus_b.i_En = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      tick();
      chk("noblank", pack_b(), exp_word((k % 10) == 0, (k / 2) % 5, 1'b1, p1[(k / 2) % 5]));
    end
    tick();
    chk("pre_async", pack_b(), exp_word(1'b0, 0, 1'b1, 7'h40));

    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_b", pack_b(), {16'd0, 1'b0, 3'd0, 5'b11111, 7'h7F});
    chk("async_rst_a", pack_a(), {16'd0, 1'b0, 3'd0, 5'b11111, 7'h7F});
    tick();
    chk("async_hold_b", pack_b(), {16'd0, 1'b0, 3'd0, 5'b11111, 7'h7F});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
